// File: rtl/aes_pkg.sv
// Shared AES-128 types, constant tables and byte/column helper functions.
package aes_pkg;

    localparam int unsigned NR      = 10;
    localparam int unsigned BLOCK_W = 128;
    localparam int unsigned RND_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Round constants for rounds 1..10, round 1 in the top byte.
    localparam logic [79:0] RCON = 80'h01_02_04_08_10_20_40_80_1b_36;

    // Forward S-box, entry 0x00 in the top byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] idx;
        idx = {~b, 3'b000};
        return SBOX[idx +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [RND_W-1:0] r);
        logic [RND_W-1:0] k;
        logic [6:0]       idx;
        if (r == '0 || r > RND_W'(NR)) begin
            return 8'h00;
        end
        k   = RND_W'(NR) - r;
        idx = {k, 3'b000};
        return RCON[idx +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One MixColumns column, row 0 in the top byte.
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

endpackage

// File: rtl/aes_round_unit.sv
// One combinational AES-128 round with on-the-fly round-key expansion.
module aes_round_unit
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] state,
    input  logic [BLOCK_W-1:0] rkey,
    input  logic [RND_W-1:0]   rnd,
    input  logic               is_last,
    output logic [BLOCK_W-1:0] state_next,
    output logic [BLOCK_W-1:0] rkey_next
);

    logic [BLOCK_W-1:0] shifted;
    logic [BLOCK_W-1:0] mixed;
    logic [31:0]        temp;

    // SubBytes fused with ShiftRows: row r of column c comes from column (c+r)%4.
    always_comb begin
        shifted = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shifted[BLOCK_W-1-8*(4*c+r) -: 8] =
                    sbox(state[BLOCK_W-1-8*(4*((c+r)%4)+r) -: 8]);
            end
        end
    end

    always_comb begin
        mixed = '0;
        for (int c = 0; c < 4; c++) begin
            mixed[BLOCK_W-1-32*c -: 32] = mix_column(shifted[BLOCK_W-1-32*c -: 32]);
        end
    end

    // Next round key from the previous one: RotWord, SubWord, rcon, then xor chain.
    always_comb begin
        temp = {sbox(rkey[23:16]), sbox(rkey[15:8]), sbox(rkey[7:0]), sbox(rkey[31:24])}
               ^ {rcon(rnd), 24'h000000};
        rkey_next[127:96] = rkey[127:96] ^ temp;
        rkey_next[95:64]  = rkey[95:64]  ^ rkey_next[127:96];
        rkey_next[63:32]  = rkey[63:32]  ^ rkey_next[95:64];
        rkey_next[31:0]   = rkey[31:0]   ^ rkey_next[63:32];
    end

    assign state_next = (is_last ? shifted : mixed) ^ rkey_next;

endmodule

// File: rtl/aes_enc_iter.sv
// Iterative AES-128 encryptor doing UNROLL rounds per clock, valid/ready on both sides.
module aes_enc_iter
    import aes_pkg::*;
#(
    parameter int unsigned UNROLL = 1
)
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] plaintext,
    input  logic [BLOCK_W-1:0] key,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] cipher_text,
    output logic               busy
);

    if (UNROLL != 1 && UNROLL != 2 && UNROLL != 5 && UNROLL != 10) begin : g_bad_unroll
        $error("aes_enc_iter: UNROLL must be 1, 2, 5 or 10");
    end

    state_t             st_q, st_d;
    logic               load, step, finish, retire;
    logic [BLOCK_W-1:0] state_q, rkey_q;
    logic [RND_W-1:0]   rnd_q;

    logic [BLOCK_W-1:0] st_chain  [UNROLL+1];
    logic [BLOCK_W-1:0] key_chain [UNROLL+1];

    assign st_chain[0]  = state_q;
    assign key_chain[0] = rkey_q;

    // Chain of UNROLL rounds evaluated in a single cycle.
    for (genvar i = 0; i < int'(UNROLL); i++) begin : g_round
        logic [RND_W-1:0] idx;
        assign idx = rnd_q + RND_W'(i + 1);
        aes_round_unit u_round (
            .state      (st_chain[i]),
            .rkey       (key_chain[i]),
            .rnd        (idx),
            .is_last    (idx == RND_W'(NR)),
            .state_next (st_chain[i+1]),
            .rkey_next  (key_chain[i+1])
        );
    end

    always_comb begin
        st_d     = st_q;
        in_ready = 1'b0;
        load     = 1'b0;
        step     = 1'b0;
        finish   = 1'b0;
        retire   = 1'b0;
        unique case (st_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load = 1'b1;
                    st_d = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (rnd_q == RND_W'(NR - UNROLL)) begin
                    finish = 1'b1;
                    st_d   = DONE;
                end
            end
            DONE: begin
                // Retiring and accepting on the same edge avoids a bubble.
                in_ready = out_ready;
                if (out_ready) begin
                    retire = 1'b1;
                    if (in_valid) begin
                        load = 1'b1;
                        st_d = RUN;
                    end else begin
                        st_d = IDLE;
                    end
                end
            end
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_q <= IDLE;
            busy <= 1'b0;
        end else begin
            st_q <= st_d;
            busy <= (st_d != IDLE);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= '0;
            rkey_q      <= '0;
            rnd_q       <= '0;
            cipher_text <= '0;
            out_valid   <= 1'b0;
        end else begin
            if (load) begin
                state_q <= plaintext ^ key;
                rkey_q  <= key;
                rnd_q   <= '0;
            end else if (step) begin
                state_q <= st_chain[UNROLL];
                rkey_q  <= key_chain[UNROLL];
                rnd_q   <= rnd_q + RND_W'(UNROLL);
            end
            if (finish) begin
                cipher_text <= st_chain[UNROLL];
                out_valid   <= 1'b1;
            end else if (retire) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
